// File: rtl/ssio_pkg.sv
// rtl/ssio_pkg.sv - shared FSM encoding and parameter checks for the SSIO SDR receive framer
//
// Contents:
//   ssio_state_e : framer FSM states (IDLE, FRAME, DROP)
//   len_ok()     : true when a LEN_WIDTH-bit counter can hold MAX_LEN+1
package ssio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_DROP  = 2'd2
    } ssio_state_e;

    function automatic bit len_ok(input int len_width, input int max_len);
        longint cap;
        if (len_width < 1 || len_width > 62 || max_len < 1) begin
            return 1'b0;
        end
        cap = (longint'(1) << len_width) - longint'(1);
        return (longint'(max_len) + longint'(1)) <= cap;
    endfunction

endpackage

// File: rtl/ssio_sdr_capture_pipe.sv
// rtl/ssio_sdr_capture_pipe.sv - SDR capture register followed by PIPELINE retiming stages
//
// Ports:
//   clk, rst  : RX clock, asynchronous active-high reset
//   i_d       : raw RX data (WIDTH bits)
//   i_ctl     : raw RX data-valid qualifier
//   i_er      : raw RX error qualifier
//   o_d/o_ctl/o_er : the same signals delayed by 1+PIPELINE edges
module ssio_sdr_capture_pipe #(
    parameter int WIDTH    = 8,
    parameter int PIPELINE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_ctl,
    input  logic             i_er,
    output logic [WIDTH-1:0] o_d,
    output logic             o_ctl,
    output logic             o_er
);

    localparam int SW = WIDTH + 2;

    // Stage 0 is the capture register; stages 1..PIPELINE are pure retiming.
    logic [SW-1:0] r_stage [0:PIPELINE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= PIPELINE; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= {i_er, i_ctl, i_d};
            for (int i = 1; i <= PIPELINE; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_d   = r_stage[PIPELINE][WIDTH-1:0];
    assign o_ctl = r_stage[PIPELINE][WIDTH];
    assign o_er  = r_stage[PIPELINE][WIDTH+1];

endmodule

// File: rtl/ssio_sdr_rx_framer.sv
// rtl/ssio_sdr_rx_framer.sv - SDR receive capture, retiming and frame delimiting with length policing
//
// Ports:
//   clk, rst        : buffered RX clock, asynchronous active-high reset
//   input_d/ctl/er  : raw source-synchronous RX bus and qualifiers
//   output_q        : framed data word (0 when output_valid=0)
//   output_valid    : output_q belongs to a frame
//   output_sof/eof  : first / last word of a frame
//   output_err      : frame errored, runt or truncated (with output_eof)
//   output_len      : running frame length in words (final length with output_eof)
//   stat_good/bad/oversize : one-cycle per-frame status pulses, aligned with output_eof
module ssio_sdr_rx_framer
    import ssio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PIPELINE  = 1,
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     input_d,
    input  logic                 input_ctl,
    input  logic                 input_er,
    output logic [WIDTH-1:0]     output_q,
    output logic                 output_valid,
    output logic                 output_sof,
    output logic                 output_eof,
    output logic                 output_err,
    output logic [LEN_WIDTH-1:0] output_len,
    output logic                 stat_good,
    output logic                 stat_bad,
    output logic                 stat_oversize
);

    if (WIDTH < 1 || WIDTH > 64 || PIPELINE < 0 || PIPELINE > 4 ||
        MIN_LEN < 0 || !len_ok(LEN_WIDTH, MAX_LEN)) begin : g_bad_params
        $error("ssio_sdr_rx_framer: illegal parameter combination");
    end

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_MIN = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_LEN);

    logic [WIDTH-1:0] w_pipe_d;
    logic             w_pipe_ctl;
    logic             w_pipe_er;

    ssio_sdr_capture_pipe #(
        .WIDTH    (WIDTH),
        .PIPELINE (PIPELINE)
    ) u_capture_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_d   (input_d),
        .i_ctl (input_ctl),
        .i_er  (input_er),
        .o_d   (w_pipe_d),
        .o_ctl (w_pipe_ctl),
        .o_er  (w_pipe_er)
    );

    // Lookahead register: while a word sits here, the pipe output is the
    // word that follows it, which decides whether this one ends the frame.
    logic [WIDTH-1:0]     r_la_d;
    logic                 r_la_ctl;
    logic                 r_la_er;

    ssio_state_e          r_state;
    logic [LEN_WIDTH-1:0] r_len;
    logic                 r_sticky;

    logic [WIDTH-1:0]     r_q;
    logic                 r_valid;
    logic                 r_sof;
    logic                 r_eof;
    logic                 r_err;
    logic [LEN_WIDTH-1:0] r_len_o;
    logic                 r_good;
    logic                 r_bad;
    logic                 r_ovs;

    ssio_state_e          w_state_n;
    logic [LEN_WIDTH-1:0] w_len_n;
    logic                 w_sticky_n;
    logic                 w_valid;
    logic                 w_sof;
    logic                 w_eof;
    logic                 w_err;
    logic                 w_good;
    logic                 w_bad;
    logic                 w_ovs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_len_n    = r_len;
        w_sticky_n = r_sticky;
        w_valid    = 1'b0;
        w_sof      = 1'b0;
        w_eof      = 1'b0;
        w_err      = 1'b0;
        w_good     = 1'b0;
        w_bad      = 1'b0;
        w_ovs      = 1'b0;

        case (r_state)
            ST_IDLE, ST_FRAME: begin
                if (r_la_ctl) begin
                    w_valid    = 1'b1;
                    w_sof      = (r_state == ST_IDLE);
                    w_len_n    = (r_state == ST_IDLE) ? LEN_ONE : r_len + LEN_ONE;
                    w_sticky_n = ((r_state == ST_IDLE) ? 1'b0 : r_sticky) | r_la_er;
                    w_state_n  = ST_FRAME;
                    if (!w_pipe_ctl) begin
                        w_eof     = 1'b1;
                        w_err     = w_sticky_n | (w_len_n < LEN_MIN);
                        w_good    = ~w_err;
                        w_bad     = w_err;
                        w_state_n = ST_IDLE;
                    end else if (w_len_n == LEN_MAX) begin
                        // Frame would exceed MAX_LEN: close it here as bad
                        // and discard the rest of the burst in DROP.
                        w_eof     = 1'b1;
                        w_err     = 1'b1;
                        w_bad     = 1'b1;
                        w_ovs     = 1'b1;
                        w_state_n = ST_DROP;
                    end
                end else begin
                    // Only reachable from IDLE; FRAME always exits on the eof word.
                    w_state_n = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!r_la_ctl) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_la_d   <= '0;
            r_la_ctl <= 1'b0;
            r_la_er  <= 1'b0;
            r_len    <= '0;
            r_sticky <= 1'b0;
            r_q      <= '0;
            r_valid  <= 1'b0;
            r_sof    <= 1'b0;
            r_eof    <= 1'b0;
            r_err    <= 1'b0;
            r_len_o  <= '0;
            r_good   <= 1'b0;
            r_bad    <= 1'b0;
            r_ovs    <= 1'b0;
        end else begin
            r_la_d   <= w_pipe_d;
            r_la_ctl <= w_pipe_ctl;
            r_la_er  <= w_pipe_er;
            r_len    <= w_len_n;
            r_sticky <= w_sticky_n;
            r_q      <= w_valid ? r_la_d : '0;
            r_valid  <= w_valid;
            r_sof    <= w_sof;
            r_eof    <= w_eof;
            r_err    <= w_err;
            r_len_o  <= w_valid ? w_len_n : '0;
            r_good   <= w_good;
            r_bad    <= w_bad;
            r_ovs    <= w_ovs;
        end
    end

    assign output_q      = r_q;
    assign output_valid  = r_valid;
    assign output_sof    = r_sof;
    assign output_eof    = r_eof;
    assign output_err    = r_err;
    assign output_len    = r_len_o;
    assign stat_good     = r_good;
    assign stat_bad      = r_bad;
    assign stat_oversize = r_ovs;

endmodule

// File: tb/tb_ssio_sdr_rx_framer.sv
// tb/tb_ssio_sdr_rx_framer.sv - self-checking bench for ssio_sdr_rx_framer across PIPELINE=0..4
module tb_ssio_sdr_rx_framer;

    localparam int NP = 5;
    localparam int NV = 12;

    typedef struct {
        int nwords;
        int er_idx;
        bit er_gap;
        int gap;
        int exp_len;
        bit exp_err;
        bit exp_ovs;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        bit         sof;
        bit         eof;
        bit         err;
        int         len;
        bit         ovs;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] input_d;
    logic       input_ctl;
    logic       input_er;

    logic [7:0]  o_q     [NP];
    logic        o_valid [NP];
    logic        o_sof   [NP];
    logic        o_eof   [NP];
    logic        o_err   [NP];
    logic [15:0] o_len   [NP];
    logic        o_good  [NP];
    logic        o_bad   [NP];
    logic        o_ovs   [NP];

    exp_t sb [NP][$];
    vec_t vecs [NV];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string msg);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s", msg);
    endtask

    function automatic bit outs_zero(input int p);
        return o_q[p] == 8'h00 && !o_valid[p] && !o_sof[p] && !o_eof[p] && !o_err[p] &&
               o_len[p] == 16'h0 && !o_good[p] && !o_bad[p] && !o_ovs[p];
    endfunction

    task automatic monitor(input int p);
        exp_t e;
        bit   ok;
        if (o_valid[p]) begin
            if (sb[p].size() == 0) begin
                chk(1'b0, $sformatf("unexpected_valid P=%0d cyc=%0d q=%h sof=%b eof=%b len=%0d want no word",
                                    p, cyc, o_q[p], o_sof[p], o_eof[p], o_len[p]));
            end else begin
                e  = sb[p].pop_front();
                ok = o_q[p] == e.d && o_sof[p] == e.sof && o_eof[p] == e.eof &&
                     (!e.eof || o_err[p] == e.err) &&
                     (!(e.eof || e.sof) || o_len[p] == 16'(e.len)) &&
                     cyc == e.cyc + p + 2 &&
                     o_good[p] == (e.eof && !e.err) && o_bad[p] == (e.eof && e.err) &&
                     o_ovs[p] == e.ovs;
                chk(ok, $sformatf("word P=%0d got cyc=%0d q=%h sof=%b eof=%b err=%b len=%0d gbo=%b%b%b want cyc=%0d q=%h sof=%b eof=%b err=%b len=%0d ovs=%b",
                                  p, cyc, o_q[p], o_sof[p], o_eof[p], o_err[p], o_len[p],
                                  o_good[p], o_bad[p], o_ovs[p],
                                  e.cyc + p + 2, e.d, e.sof, e.eof, e.err, e.len, e.ovs));
            end
        end else begin
            chk(outs_zero(p), $sformatf("idle_zero P=%0d cyc=%0d q=%h sof=%b eof=%b err=%b len=%0d gbo=%b%b%b want all 0",
                                        p, cyc, o_q[p], o_sof[p], o_eof[p], o_err[p], o_len[p],
                                        o_good[p], o_bad[p], o_ovs[p]));
        end
    endtask

    for (genvar gp = 0; gp < NP; gp++) begin : g_dut
        ssio_sdr_rx_framer #(
            .WIDTH     (8),
            .PIPELINE  (gp),
            .MIN_LEN   (64),
            .MAX_LEN   (1518),
            .LEN_WIDTH (16)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .input_d       (input_d),
            .input_ctl     (input_ctl),
            .input_er      (input_er),
            .output_q      (o_q[gp]),
            .output_valid  (o_valid[gp]),
            .output_sof    (o_sof[gp]),
            .output_eof    (o_eof[gp]),
            .output_err    (o_err[gp]),
            .output_len    (o_len[gp]),
            .stat_good     (o_good[gp]),
            .stat_bad      (o_bad[gp]),
            .stat_oversize (o_ovs[gp])
        );

        always @(posedge clk) begin
            #2;
            monitor(gp);
        end
    end

    function automatic exp_t mk(input logic [7:0] d, input bit sof, input bit eof,
                                input bit err, input int len, input bit ovs);
        exp_t r;
        r.d   = d;
        r.sof = sof;
        r.eof = eof;
        r.err = err;
        r.len = len;
        r.ovs = ovs;
        r.cyc = 0;
        return r;
    endfunction

    // Called on a negedge: sets the inputs for the next rising edge, queues
    // the expected output word, then waits for the following negedge.
    task automatic drive_word(input bit ctl, input bit er, input logic [7:0] d,
                              input bit push, input exp_t rec);
        exp_t r;
        input_ctl = ctl;
        input_er  = er;
        input_d   = d;
        if (push) begin
            r     = rec;
            r.cyc = cyc + 1;
            for (int p = 0; p < NP; p++) sb[p].push_back(r);
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t none;
        bit   last;
        none = mk(8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        //            nwords er_idx er_gap gap exp_len exp_err exp_ovs
        vecs[0]  = '{   64,   -1,   1'b0,  3,    64,   1'b0,   1'b0};
        vecs[1]  = '{   10,   -1,   1'b0,  2,    10,   1'b1,   1'b0};
        vecs[2]  = '{  100,   50,   1'b0,  2,   100,   1'b1,   1'b0};
        vecs[3]  = '{  100,   -1,   1'b1,  2,   100,   1'b0,   1'b0};
        vecs[4]  = '{ 1600,   -1,   1'b0,  1,  1518,   1'b1,   1'b1};
        vecs[5]  = '{   70,   -1,   1'b0,  1,    70,   1'b0,   1'b0};
        vecs[6]  = '{    1,   -1,   1'b0,  1,     1,   1'b1,   1'b0};
        vecs[7]  = '{    1,   -1,   1'b0,  2,     1,   1'b1,   1'b0};
        vecs[8]  = '{   64,   -1,   1'b0,  1,    64,   1'b0,   1'b0};
        vecs[9]  = '{   63,   -1,   1'b0,  1,    63,   1'b1,   1'b0};
        vecs[10] = '{ 1518,   -1,   1'b0,  1,  1518,   1'b0,   1'b0};
        vecs[11] = '{ 1519,   -1,   1'b0,  2,  1518,   1'b1,   1'b1};

        rst       = 1'b1;
        input_d   = 8'h00;
        input_ctl = 1'b0;
        input_er  = 1'b0;
        repeat (3) @(negedge clk);
        for (int p = 0; p < NP; p++)
            chk(outs_zero(p), $sformatf("reset_state P=%0d valid=%b q=%h len=%0d want all 0",
                                        p, o_valid[p], o_q[p], o_len[p]));
        rst = 1'b0;

        for (int i = 0; i < 10; i++) drive_word(1'b0, 1'b0, 8'h00, 1'b0, none);

        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < vecs[v].nwords; i++) begin
                last = (i == vecs[v].exp_len - 1);
                drive_word(1'b1, i == vecs[v].er_idx, 8'(i), i < vecs[v].exp_len,
                           mk(8'(i), i == 0, last, last && vecs[v].exp_err, i + 1,
                              last && vecs[v].exp_ovs));
            end
            for (int g = 0; g < vecs[v].gap; g++)
                drive_word(1'b0, vecs[v].er_gap, 8'hA5, 1'b0, none);
        end

        // Reset in the middle of a frame: words already emitted stay, the rest are lost.
        for (int i = 0; i < 30; i++)
            drive_word(1'b1, 1'b0, 8'(i + 192), 1'b1, mk(8'(i + 192), i == 0, 1'b0, 1'b0, i + 1, 1'b0));
        rst = 1'b1;
        for (int p = 0; p < NP; p++) sb[p].delete();
        #1;
        for (int p = 0; p < NP; p++)
            chk(outs_zero(p), $sformatf("midframe_reset P=%0d valid=%b q=%h eof=%b gbo=%b%b%b want all 0",
                                        p, o_valid[p], o_q[p], o_eof[p], o_good[p], o_bad[p], o_ovs[p]));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            last = (i == 19);
            drive_word(1'b1, 1'b0, 8'(i + 32), 1'b1, mk(8'(i + 32), i == 0, last, last, i + 1, 1'b0));
        end

        for (int i = 0; i < 12; i++) drive_word(1'b0, 1'b0, 8'h00, 1'b0, none);

        for (int p = 0; p < NP; p++)
            chk(sb[p].size() == 0, $sformatf("drain P=%0d words_outstanding=%0d want 0", p, sb[p].size()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
